uart_tx_drain: RTL and testbench

Serial transmit stage that sits directly downstream of the synchronous byte FIFO. It pops one word at a time through the FIFO read handshake and shifts it out on a single UART line, LSB first. Frames are start bit, WIDTH data bits, an optional even-parity bit, and one stop bit. It drains the FIFO back-to-back while `enable` is high and the FIFO reports not-empty.

---
 rtl/uart_tx_drain.sv | 140 ++++++++++++++
 tb/tb_uart_tx_drain.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains a synchronous FIFO one word per frame:
// start bit, WIDTH data bits LSB first, optional even parity, one stop bit.
module uart_tx_drain #(
   parameter int CLKS_PER_BIT = 16,
   parameter int WIDTH        = 8,
   parameter int PARITY_EN    = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy,
   output logic             tx_done
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int CNT_W  = $clog2(WIDTH) + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [CNT_W-1:0]  bit_q, bit_d;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;
   logic              bit_end;

   assign bit_end = (baud_q == BAUD_LAST);

   // The baud counter restarts whenever a new line state is entered.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + BAUD_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (enable && !fifo_empty) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            baud_d  = '0;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            baud_d  = '0;
            bit_d   = '0;
            shift_d = fifo_data;
            par_d   = ^fifo_data;
            state_d = S_START;
         end
         S_START: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + CNT_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            baud_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Line level is decoded from the next state so tx leaves a flop.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   assign tx         = tx_q;
   assign fifo_rd_en = (state_q == S_FETCH);
   assign busy       = (state_q != S_IDLE);
   assign tx_done    = (state_q == S_STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: channel 0 without parity, channel 1 with even parity,
// both at 4 clocks per bit; a line decoder checks frames against a byte scoreboard.
module tb_uart_tx_drain;

   logic       clk;
   logic       rst;
   logic       en    [2];
   logic       emp   [2];
   logic [7:0] fdata [2];
   logic       rd    [2];
   logic       txl   [2];
   logic       busy  [2];
   logic       done  [2];

   uart_tx_drain #(.CLKS_PER_BIT(4), .WIDTH(8), .PARITY_EN(0)) u_np (
      .clk(clk), .rst(rst), .enable(en[0]), .fifo_empty(emp[0]), .fifo_data(fdata[0]),
      .fifo_rd_en(rd[0]), .tx(txl[0]), .busy(busy[0]), .tx_done(done[0])
   );

   uart_tx_drain #(.CLKS_PER_BIT(4), .WIDTH(8), .PARITY_EN(1)) u_par (
      .clk(clk), .rst(rst), .enable(en[1]), .fifo_empty(emp[1]), .fifo_data(fdata[1]),
      .fifo_rd_en(rd[1]), .tx(txl[1]), .busy(busy[1]), .tx_done(done[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [7:0] fq0[$];
   logic [7:0] fq1[$];
   logic [7:0] exp0[$];
   logic [7:0] exp1[$];

   bit         in_fr    [2];
   int         lc       [2];
   logic [7:0] cur      [2];
   logic       prev     [2];
   int         frames   [2];
   int         pops     [2];
   int         rd_cyc   [2];
   int         st_cyc   [2];
   int         gap      [2];
   int         done_cyc [2];
   int         done_cnt [2];
   int         hi_run   [2];
   int         last_hi  [2];
   logic       par_seen [2];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic line_bit(logic [7:0] b, int idx, bit par);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (par && idx == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic push(int ch, logic [7:0] b);
      if (ch == 0) begin
         fq0.push_back(b);
         exp0.push_back(b);
         emp[0] = 1'b0;
      end else begin
         fq1.push_back(b);
         exp1.push_back(b);
         emp[1] = 1'b0;
      end
   endtask

   task automatic mon(int ch, bit was_rst);
      int   flen;
      logic t;
      flen = (ch == 1) ? 44 : 40;
      t    = txl[ch];
      if (was_rst) begin
         chk("rst_tx", 32'(t), 1);
         chk("rst_busy", 32'(busy[ch]), 0);
         chk("rst_done", 32'(done[ch]), 0);
         chk("rst_rd", 32'(rd[ch]), 0);
         in_fr[ch]  = 1'b0;
         prev[ch]   = 1'b1;
         hi_run[ch] = 0;
         return;
      end
      if (rd[ch] === 1'b1) rd_cyc[ch] = cyc;
      if (done[ch] === 1'b1) begin
         done_cyc[ch] = cyc;
         done_cnt[ch]++;
      end
      if (!in_fr[ch]) begin
         if (prev[ch] === 1'b1 && t === 1'b0) begin
            in_fr[ch] = 1'b1;
            lc[ch]    = 0;
            if (ch == 0 && exp0.size() > 0) cur[ch] = exp0.pop_front();
            else if (ch == 1 && exp1.size() > 0) cur[ch] = exp1.pop_front();
            else chk("unexpected_frame", 1, 0);
            chk("pop_to_start", 32'(cyc - rd_cyc[ch]), 2);
            if (st_cyc[ch] >= 0) gap[ch] = cyc - st_cyc[ch];
            st_cyc[ch]  = cyc;
            last_hi[ch] = hi_run[ch];
         end else begin
            chk("idle_done", 32'(done[ch]), 0);
         end
      end
      if (in_fr[ch]) begin
         chk("line", 32'(t), 32'(line_bit(cur[ch], lc[ch] / 4, ch == 1)));
         chk("done_pos", 32'(done[ch]), 32'(lc[ch] == flen - 1));
         chk("busy_frame", 32'(busy[ch]), 1);
         if (lc[ch] == 38) par_seen[ch] = t;
         if (lc[ch] == flen - 1) begin
            in_fr[ch] = 1'b0;
            frames[ch]++;
         end else begin
            lc[ch]++;
         end
      end
      hi_run[ch] = (t === 1'b1) ? hi_run[ch] + 1 : 0;
      prev[ch]   = t;
   endtask

   // One clock: the FIFO model serves pops seen at the edge, then both lines are decoded.
   task automatic tick();
      logic r0, r1;
      bit   rs;
      r0 = rd[0];
      r1 = rd[1];
      rs = (rst === 1'b1);
      @(posedge clk);
      #1;
      cyc++;
      if (r0 === 1'b1) begin
         pops[0]++;
         if (fq0.size() == 0) chk("pop_empty0", 1, 0);
         else fdata[0] = fq0.pop_front();
      end
      if (r1 === 1'b1) begin
         pops[1]++;
         if (fq1.size() == 0) chk("pop_empty1", 1, 0);
         else fdata[1] = fq1.pop_front();
      end
      emp[0] = (fq0.size() == 0);
      emp[1] = (fq1.size() == 0);
      mon(0, rs);
      mon(1, rs);
   endtask

   task automatic wait_frames(int ch, int n, int budget);
      int k = 0;
      while (frames[ch] < n && k < budget) begin
         tick();
         k++;
      end
      chk("timeout_frames", 32'(frames[ch] >= n), 1);
   endtask

   task automatic wait_lc(int ch, int n, int budget);
      int k = 0;
      while (!(in_fr[ch] && lc[ch] == n) && k < budget) begin
         tick();
         k++;
      end
      chk("timeout_lc", 32'(in_fr[ch] && lc[ch] == n), 1);
   endtask

   initial begin
      int p0, f0, d0;
      for (int i = 0; i < 2; i++) begin
         en[i] = 1'b0; emp[i] = 1'b1; fdata[i] = 8'h00;
         in_fr[i] = 1'b0; lc[i] = 0; cur[i] = 8'h00; prev[i] = 1'b1;
         frames[i] = 0; pops[i] = 0; rd_cyc[i] = -100; st_cyc[i] = -1; gap[i] = 0;
         done_cyc[i] = 0; done_cnt[i] = 0; hi_run[i] = 0; last_hi[i] = 0; par_seen[i] = 1'bx;
      end

      // Reset for two cycles, then enabled with an empty FIFO.
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      en[0] = 1'b1;
      en[1] = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         for (int c = 0; c < 2; c++) begin
            chk("empty_tx", 32'(txl[c]), 1);
            chk("empty_busy", 32'(busy[c]), 0);
            chk("empty_rd", 32'(rd[c]), 0);
            chk("empty_done", 32'(done[c]), 0);
         end
      end

      // Single byte 0xA5.
      push(0, 8'hA5);
      wait_frames(0, 1, 200);
      chk("a5_pops", 32'(pops[0]), 1);
      chk("a5_done_cycle", 32'(done_cyc[0] - st_cyc[0]), 39);
      chk("a5_done_cnt", 32'(done_cnt[0]), 1);
      tick();
      chk("a5_busy_after", 32'(busy[0]), 0);
      for (int i = 0; i < 10; i++) tick();

      // Back-to-back 0x00, 0xFF.
      push(0, 8'h00);
      push(0, 8'hFF);
      wait_frames(0, 3, 300);
      chk("b2b_pops", 32'(pops[0]), 3);
      chk("b2b_gap", 32'(gap[0]), 43);
      chk("b2b_high_run", 32'(last_hi[0]), 7);
      for (int i = 0; i < 10; i++) tick();

      // Even parity channel.
      push(1, 8'h07);
      wait_frames(1, 1, 200);
      chk("par07_len", 32'(done_cyc[1] - st_cyc[1]), 43);
      chk("par07_bit", 32'(par_seen[1]), 1);
      push(1, 8'h03);
      wait_frames(1, 2, 200);
      chk("par03_bit", 32'(par_seen[1]), 0);
      chk("par_pops", 32'(pops[1]), 2);
      for (int i = 0; i < 10; i++) tick();

      // Enable dropped during data bit 3 with two bytes queued.
      p0 = pops[0];
      f0 = frames[0];
      d0 = done_cnt[0];
      push(0, 8'h3C);
      push(0, 8'hC3);
      wait_lc(0, 17, 200);
      en[0] = 1'b0;
      wait_frames(0, f0 + 1, 200);
      for (int i = 0; i < 60; i++) tick();
      chk("en_pops", 32'(pops[0]), 32'(p0 + 1));
      chk("en_done", 32'(done_cnt[0]), 32'(d0 + 1));
      chk("en_busy", 32'(busy[0]), 0);
      chk("en_left", 32'(emp[0]), 0);
      chk("en_frames", 32'(frames[0]), 32'(f0 + 1));

      // Reset during data bit 5, new byte waiting on release.
      p0 = pops[0];
      f0 = frames[0];
      en[0] = 1'b1;
      wait_lc(0, 25, 200);
      rst = 1'b1;
      push(0, 8'h5A);
      tick();
      rst = 1'b0;
      tick();
      chk("rst_fresh_pop", 32'(rd[0]), 1);
      wait_frames(0, f0 + 1, 200);
      chk("rst_pops", 32'(pops[0]), 32'(p0 + 2));
      chk("rst_sb_empty", 32'(exp0.size()), 0);
      tick();
      chk("rst_busy_after", 32'(busy[0]), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
